maxpool_relu1: RTL and testbench

//  Stage directly downstream of the 3-channel conv1 stage. Consumes its 24x24 raster

---
 rtl/maxpool_relu1_if.sv | 24 ++
 rtl/maxpool_relu1.sv | 99 +++++++++
 tb/tb_maxpool_relu1.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/maxpool_relu1_if.sv
// Stream bundle between conv1 and the pooling stage: raster input side and pooled output side.
interface maxpool_relu1_if #(
  parameter int unsigned DATA_BITS = 15
);
  logic                        valid_in;
  logic signed [DATA_BITS-1:0] conv_in_1;
  logic signed [DATA_BITS-1:0] conv_in_2;
  logic signed [DATA_BITS-1:0] conv_in_3;
  logic signed [DATA_BITS-1:0] pool_out_1;
  logic signed [DATA_BITS-1:0] pool_out_2;
  logic signed [DATA_BITS-1:0] pool_out_3;
  logic                        valid_out_pool;
  logic                        frame_done;

  modport master (
    output valid_in, conv_in_1, conv_in_2, conv_in_3,
    input  pool_out_1, pool_out_2, pool_out_3, valid_out_pool, frame_done
  );

  modport slave (
    input  valid_in, conv_in_1, conv_in_2, conv_in_3,
    output pool_out_1, pool_out_2, pool_out_3, valid_out_pool, frame_done
  );
endinterface

// File: rtl/maxpool_relu1.sv
// 2x2 stride-2 max pooling followed by ReLU on a 3-channel raster stream, with a
// half-row line buffer per channel holding the horizontal maxima of each even row.
module maxpool_relu1 #(
  parameter int unsigned IN_WIDTH  = 24,
  parameter int unsigned IN_HEIGHT = 24,
  parameter int unsigned DATA_BITS = 15
) (
  input logic             clk,
  input logic             rst_n,
  maxpool_relu1_if.slave  bus_io
);

  localparam int unsigned ColW  = $clog2(IN_WIDTH);
  localparam int unsigned RowW  = $clog2(IN_HEIGHT);
  localparam int unsigned HalfW = IN_WIDTH / 2;
  localparam int unsigned AddrW = ColW - 1;
  localparam int unsigned NumCh = 3;

  typedef logic signed [DATA_BITS-1:0] data_t;

  data_t            sample   [NumCh];
  data_t            pair_q   [NumCh];
  data_t            out_q    [NumCh];
  data_t            lb_q     [NumCh][HalfW];
  data_t            h_d      [NumCh];
  data_t            m_d      [NumCh];
  data_t            relu_d   [NumCh];
  logic [ColW-1:0]  col_q;
  logic [RowW-1:0]  row_q;
  logic [AddrW-1:0] lb_addr;
  logic             col_last, row_last, fire, lb_we;
  logic             vout_q, fdone_q;

  assign sample[0] = bus_io.conv_in_1;
  assign sample[1] = bus_io.conv_in_2;
  assign sample[2] = bus_io.conv_in_3;

  assign lb_addr  = col_q[ColW-1:1];
  assign col_last = (col_q == ColW'(IN_WIDTH - 1));
  assign row_last = (row_q == RowW'(IN_HEIGHT - 1));
  assign fire     = bus_io.valid_in & col_q[0] & row_q[0];
  assign lb_we    = ~rst_n & bus_io.valid_in & col_q[0] & ~row_q[0];

  // Signed compares over the full width; ties resolve to the same value either way.
  always_comb begin
    for (int ch = 0; ch < NumCh; ch++) begin
      h_d[ch]    = (pair_q[ch] > sample[ch]) ? pair_q[ch] : sample[ch];
      m_d[ch]    = (lb_q[ch][lb_addr] > h_d[ch]) ? lb_q[ch][lb_addr] : h_d[ch];
      relu_d[ch] = m_d[ch][DATA_BITS-1] ? '0 : m_d[ch];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      vout_q  <= 1'b0;
      fdone_q <= 1'b0;
      for (int ch = 0; ch < NumCh; ch++) begin
        pair_q[ch] <= '0;
        out_q[ch]  <= '0;
      end
    end else begin
      vout_q  <= fire;
      fdone_q <= fire & col_last & row_last;
      if (bus_io.valid_in) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
        for (int ch = 0; ch < NumCh; ch++) begin
          if (!col_q[0]) begin
            pair_q[ch] <= sample[ch];
          end else if (row_q[0]) begin
            out_q[ch] <= relu_d[ch];
          end
        end
      end
    end
  end

  // Line buffer left unreset so it can map onto plain single-port storage.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      for (int ch = 0; ch < NumCh; ch++) begin
        lb_q[ch][lb_addr] <= h_d[ch];
      end
    end
  end

  assign bus_io.pool_out_1     = out_q[0];
  assign bus_io.pool_out_2     = out_q[1];
  assign bus_io.pool_out_3     = out_q[2];
  assign bus_io.valid_out_pool = vout_q;
  assign bus_io.frame_done     = fdone_q;

endmodule

// File: tb/tb_maxpool_relu1.sv
// Directed bench for maxpool_relu1: uniform-window frames from a table, then ramp,
// gapped, reset-mid-frame and back-to-back frame sequences; outputs checked every cycle.
module tb_maxpool_relu1;

  typedef logic signed [14:0] px_t;
  typedef logic [3:0][14:0]   win_t;

  typedef struct packed {
    win_t w1;
    win_t w2;
    win_t w3;
    px_t  e1;
    px_t  e2;
    px_t  e3;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   fire_cnt;
  int   fd_cnt;
  bit   chk_en;
  bit   exp_fire;
  bit   exp_fd;
  px_t  exp_hold [3];

  maxpool_relu1_if #(.DATA_BITS(15)) bus_if ();

  maxpool_relu1 #(
    .IN_WIDTH (24),
    .IN_HEIGHT(24),
    .DATA_BITS(15)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic win_t win(input int a, input int b, input int c, input int d);
    win_t w;
    w[0] = 15'(a);
    w[1] = 15'(b);
    w[2] = 15'(c);
    w[3] = 15'(d);
    return w;
  endfunction

  task automatic check_eq(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // One clock: check what the last posedge produced, then drive this cycle and predict.
  task automatic step(input bit v, input bit r, input px_t a1, input px_t a2, input px_t a3,
                      input bit fire, input bit fd, input px_t e1, input px_t e2,
                      input px_t e3);
    @(negedge clk);
    if (chk_en) begin
      checks++;
      if (bus_if.valid_out_pool !== exp_fire || bus_if.frame_done !== exp_fd) begin
        failures++;
        $display("FAIL strobe t=%0t got v=%b fd=%b want v=%b fd=%b", $time,
                 bus_if.valid_out_pool, bus_if.frame_done, exp_fire, exp_fd);
      end
      checks++;
      if (bus_if.pool_out_1 !== exp_hold[0] || bus_if.pool_out_2 !== exp_hold[1] ||
          bus_if.pool_out_3 !== exp_hold[2]) begin
        failures++;
        $display("FAIL data t=%0t got %0d/%0d/%0d want %0d/%0d/%0d", $time,
                 bus_if.pool_out_1, bus_if.pool_out_2, bus_if.pool_out_3,
                 exp_hold[0], exp_hold[1], exp_hold[2]);
      end
      if (bus_if.valid_out_pool === 1'b1) fire_cnt++;
      if (bus_if.frame_done === 1'b1) fd_cnt++;
    end
    rst_n            = r;
    bus_if.valid_in  = v;
    bus_if.conv_in_1 = a1;
    bus_if.conv_in_2 = a2;
    bus_if.conv_in_3 = a3;
    if (r) begin
      exp_fire = 1'b0;
      exp_fd   = 1'b0;
      exp_hold = '{15'sd0, 15'sd0, 15'sd0};
    end else begin
      exp_fire = fire;
      exp_fd   = fd;
      if (fire) exp_hold = '{e1, e2, e3};
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // Every 2x2 window of the frame carries the same pattern.
  task automatic frame_win(input vec_t tv);
    for (int r = 0; r < 24; r++) begin
      for (int c = 0; c < 24; c++) begin
        int  idx;
        bit  f;
        idx = (r % 2) * 2 + (c % 2);
        f   = (r % 2 == 1) && (c % 2 == 1);
        step(1'b1, 1'b0, px_t'(tv.w1[idx]), px_t'(tv.w2[idx]), px_t'(tv.w3[idx]),
             f, f && r == 23 && c == 23, tv.e1, tv.e2, tv.e3);
      end
    end
  endtask

  // ch1 = r*24+c, ch2 = 0, ch3 = 575-(r*24+c).
  task automatic ramp(input int n, input bit gaps);
    for (int p = 0; p < n; p++) begin
      int r, c, ex1, ex3;
      bit f;
      r = p / 24;
      c = p % 24;
      if (gaps) begin
        for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) idle();
      end
      f   = (r % 2 == 1) && (c % 2 == 1);
      ex1 = ((r / 2) * 2 + 1) * 24 + (c / 2) * 2 + 1;
      ex3 = 575 - ((r / 2) * 2 * 24 + (c / 2) * 2);
      step(1'b1, 1'b0, px_t'(p), '0, px_t'(575 - p), f, f && p == 575,
           px_t'(ex1), '0, px_t'(ex3));
    end
  endtask

  vec_t vecs [6];

  initial begin
    checks   = 0;
    failures = 0;
    fire_cnt = 0;
    fd_cnt   = 0;
    chk_en   = 1'b0;
    exp_fire = 1'b0;
    exp_fd   = 1'b0;
    exp_hold = '{15'sd0, 15'sd0, 15'sd0};
    rst_n            = 1'b1;
    bus_if.valid_in  = 1'b0;
    bus_if.conv_in_1 = '0;
    bus_if.conv_in_2 = '0;
    bus_if.conv_in_3 = '0;

    vecs[0] = '{w1: win(-100, -100, -100, -100), w2: win(-100, -100, -100, -100),
                w3: win(-5, -3, -7, -1), e1: 15'sd0, e2: 15'sd0, e3: 15'sd0};
    vecs[1] = '{w1: win(-5, 3, -7, -1), w2: win(1000, 0, 0, 0),
                w3: win(0, 0, 0, 16383), e1: 15'sd3, e2: 15'sd1000, e3: 15'sd16383};
    vecs[2] = '{w1: win(0, 0, 1000, 0), w2: win(-1000, 0, 0, 0),
                w3: win(0, 16383, 0, 0), e1: 15'sd1000, e2: 15'sd0, e3: 15'sd16383};
    vecs[3] = '{w1: win(-1, 5, 2, -2), w2: win(-16384, -16384, -16384, -16384),
                w3: win(16383, -16384, 0, 1), e1: 15'sd5, e2: 15'sd0, e3: 15'sd16383};
    vecs[4] = '{w1: win(7, 7, 7, 7), w2: win(4, 3, 2, 1),
                w3: win(2, 9, -9, 3), e1: 15'sd7, e2: 15'sd4, e3: 15'sd9};
    vecs[5] = '{w1: win(10, -20, 30, -40), w2: win(100, 200, 50, 60),
                w3: win(-300, -200, -100, -50), e1: 15'sd30, e2: 15'sd200, e3: 15'sd0};

    do_reset();
    chk_en = 1'b1;
    idle();
    idle();

    // Table frames run back to back; each must produce 144 outputs and one frame_done.
    for (int i = 0; i < 6; i++) begin
      fire_cnt = 0;
      fd_cnt   = 0;
      frame_win(vecs[i]);
      idle();
      idle();
      check_eq($sformatf("vec%0d_outputs", i), fire_cnt, 144);
      check_eq($sformatf("vec%0d_frame_done", i), fd_cnt, 1);
    end

    fire_cnt = 0;
    fd_cnt   = 0;
    ramp(576, 1'b0);
    idle();
    idle();
    check_eq("ramp_outputs", fire_cnt, 144);
    check_eq("ramp_frame_done", fd_cnt, 1);

    fire_cnt = 0;
    fd_cnt   = 0;
    ramp(576, 1'b1);
    repeat (3) idle();
    check_eq("gaps_outputs", fire_cnt, 144);
    check_eq("gaps_frame_done", fd_cnt, 1);

    ramp(300, 1'b0);
    do_reset();
    fire_cnt = 0;
    fd_cnt   = 0;
    ramp(576, 1'b0);
    idle();
    idle();
    check_eq("after_reset_outputs", fire_cnt, 144);
    check_eq("after_reset_frame_done", fd_cnt, 1);

    fire_cnt = 0;
    fd_cnt   = 0;
    ramp(576, 1'b0);
    ramp(576, 1'b0);
    idle();
    idle();
    check_eq("b2b_outputs", fire_cnt, 288);
    check_eq("b2b_frame_done", fd_cnt, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
